// File: rtl/vc_arb_pkg.sv
// vc_arb_pkg: shared state encoding and index-width helper for the round-robin message arbiter
//  No ports; imported by vc_rr_priority_pick and vc_rr_msg_arbiter.
package vc_arb_pkg;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vc_rr_priority_pick.sv
// vc_rr_priority_pick: rotating priority pick, first set req bit at or after ptr
//  req     in   p_nreqs  request vector
//  ptr     in   IW       highest-priority index
//  grant   out  IW       index of the winning request
//  any_req out  1        at least one request is set
module vc_rr_priority_pick
  import vc_arb_pkg::*;
#(
  parameter int p_nreqs = 4,
  localparam int IW = idx_w(p_nreqs)
) (
  input  logic [p_nreqs-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      grant,
  output logic               any_req
);
  localparam logic [IW:0] N = (IW+1)'(p_nreqs);
  logic [p_nreqs-1:0] rot;
  logic [IW-1:0]      first;
  logic [IW:0]        sum;
  always_comb begin
    rot = p_nreqs'({req, req} >> ptr);
    first = '0;
    for (int i = p_nreqs - 1; i >= 0; i--) if (rot[i]) first = IW'(i);
    sum = {1'b0, first} + {1'b0, ptr};
    grant = sum >= N ? IW'(sum - N) : IW'(sum);
    any_req = |req;
  end
endmodule

// File: rtl/vc_rr_msg_arbiter.sv
// vc_rr_msg_arbiter: round-robin val/rdy channel arbiter with grant hold on stall and burst limit
//  clk, reset (async, active-low)
//  in_val/in_rdy/in_msg  per-requester channel, requester i at in_msg[i*W +: W]
//  out_val/out_rdy/out_msg shared output channel, out_src = granted requester index
module vc_rr_msg_arbiter
  import vc_arb_pkg::*;
#(
  parameter int p_nreqs = 4,
  parameter int p_msg_nbits = 32,
  parameter int p_max_burst = 4,
  localparam int IW = idx_w(p_nreqs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             in_val,
  output logic [p_nreqs-1:0]             in_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0] in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_nbits-1:0]         out_msg,
  output logic [IW-1:0]                  out_src
);
  localparam int BW = idx_w(p_max_burst + 1);
  arb_state_e     state_q, state_d;
  logic [IW-1:0]  ptr_q, last_q, lock_q, pick_idx, winner, nxt_ptr;
  logic [BW-1:0]  cnt_q, nxt_cnt;
  logic           any_req, xfer, hit;
  vc_rr_priority_pick #(.p_nreqs(p_nreqs)) u_pick (
    .req(in_val),
    .ptr(ptr_q),
    .grant(pick_idx),
    .any_req(any_req)
  );
  // Outputs are gated by reset so nothing is offered while reset is held.
  always_comb begin
    winner = state_q == LOCKED ? lock_q : pick_idx;
    out_val = reset && (state_q == LOCKED ? in_val[lock_q] : any_req);
    out_src = reset ? winner : '0;
    out_msg = out_val ? in_msg[winner*p_msg_nbits +: p_msg_nbits] : 'x;
    in_rdy = '0;
    in_rdy[winner] = reset && out_rdy;
    xfer = out_val && out_rdy;
    nxt_cnt = winner == last_q ? cnt_q + BW'(1) : BW'(1);
    hit = nxt_cnt == BW'(p_max_burst);
    nxt_ptr = winner == IW'(p_nreqs - 1) ? '0 : winner + IW'(1);
    // A dropped in_val while locked releases the lock (protocol violation, asserted below).
    state_d = state_q == IDLE ? (any_req && !out_rdy ? LOCKED : IDLE)
                              : (in_val[lock_q] && !out_rdy ? LOCKED : IDLE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      lock_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) lock_q <= pick_idx;
      if (xfer) begin
        last_q <= winner;
        cnt_q <= hit ? '0 : nxt_cnt;
        ptr_q <= hit ? nxt_ptr : winner;
      end
    end
  end
  a_no_x: assert property (@(posedge clk) disable iff (!reset)
    !$isunknown({in_val, out_rdy, in_rdy, out_val}));
  a_rdy_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(in_rdy));
  a_lock_held: assert property (@(posedge clk) disable iff (!reset)
    state_q == LOCKED |-> in_val[lock_q]);
endmodule

// File: tb/tb_vc_rr_msg_arbiter.sv
// tb_vc_rr_msg_arbiter: scoreboard bench for vc_rr_msg_arbiter (burst 4 and burst 1 instances)
module tb_vc_rr_msg_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 0;
  logic reset = 1;
  logic [N-1:0] in_val = '0;
  logic out_rdy = 0;
  logic [N*W-1:0] in_msg;
  logic [N-1:0] rdy_a, rdy_b, rdy;
  logic val_a, val_b, val;
  logic [W-1:0] msg_a, msg_b, msg;
  logic [1:0] src_a, src_b, src;
  logic use_b = 0;
  int checks = 0;
  int errors = 0;
  int unsigned src_seq [N];
  int unsigned exp_seq [N];
  typedef struct {
    logic [1:0]   src;
    logic [W-1:0] msg;
  } exp_t;
  exp_t exp_q [$];
  logic [W-1:0] m0;

  vc_rr_msg_arbiter #(.p_nreqs(N), .p_msg_nbits(W), .p_max_burst(4)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_a), .in_msg(in_msg),
    .out_val(val_a), .out_rdy(out_rdy), .out_msg(msg_a), .out_src(src_a)
  );
  vc_rr_msg_arbiter #(.p_nreqs(N), .p_msg_nbits(W), .p_max_burst(1)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy_b), .in_msg(in_msg),
    .out_val(val_b), .out_rdy(out_rdy), .out_msg(msg_b), .out_src(src_b)
  );

  assign rdy = use_b ? rdy_b : rdy_a;
  assign val = use_b ? val_b : val_a;
  assign msg = use_b ? msg_b : msg_a;
  assign src = use_b ? src_b : src_a;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < N; i++) in_msg[i*W +: W] = {8'(i), 24'(src_seq[i])};

  always @(posedge clk)
    if (reset)
      for (int i = 0; i < N; i++)
        if (in_val[i] && rdy[i]) src_seq[i] <= src_seq[i] + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_xfer(input int s);
    exp_q.push_back('{2'(s), {8'(s), 24'(exp_seq[s])}});
    exp_seq[s]++;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_val = '0;
    out_rdy = 0;
    reset = 0;
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  function automatic string trace();
    string s = "";
    for (int i = 0; i < N; i++)
      s = {s, $sformatf("%b%b:%h ", in_val[i], rdy[i], in_msg[i*W +: W])};
    return {s, $sformatf("| %b%b:%h src%0d", val, out_rdy, msg, src)};
  endfunction

  always @(negedge clk)
    if (reset && val && out_rdy) begin
      exp_t e;
      if (exp_q.size() == 0) chk("unexpected_xfer", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("xfer_src", 32'(src), 32'(e.src));
        chk("xfer_msg", msg, e.msg);
        chk("xfer_rdy", 32'(rdy), 32'(4'b0001 << e.src));
      end
    end

  initial begin
    #1;
    reset = 0;
    in_val = 4'b1111;
    out_rdy = 1;
    #1;
    chk("rst_val", 32'(val_a), 0);
    chk("rst_rdy", 32'(rdy_a), 0);
    chk("rst_src", 32'(src_a), 0);
    // rotation with burst limit 1
    do_reset();
    use_b = 1;
    for (int i = 0; i < 8; i++) expect_xfer(i % 4);
    in_val = 4'b1111;
    out_rdy = 1;
    run(8);
    in_val = '0;
    chk("t1_pending", exp_q.size(), 0);
    // lone requester never blocked by the burst limit
    do_reset();
    use_b = 0;
    for (int i = 0; i < 6; i++) expect_xfer(0);
    in_val = 4'b0001;
    out_rdy = 1;
    run(6);
    in_val = '0;
    chk("t2_pending", exp_q.size(), 0);
    // burst of 4 then rotate
    do_reset();
    for (int i = 0; i < 10; i++) expect_xfer(i < 4 ? 0 : i < 8 ? 1 : 0);
    in_val = 4'b0011;
    out_rdy = 1;
    run(10);
    in_val = '0;
    chk("t3_pending", exp_q.size(), 0);
    // stall holds the grant and the message
    do_reset();
    in_val = 4'b0100;
    out_rdy = 0;
    m0 = {8'd2, 24'(exp_seq[2])};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_val", 32'(val), 1);
      chk("stall_src", 32'(src), 2);
      chk("stall_msg", msg, m0);
      chk("stall_rdy", 32'(rdy), 0);
      $display("%s", trace());
      @(posedge clk);
      #1;
      in_val = 4'b0101;
    end
    expect_xfer(2);
    out_rdy = 1;
    run(1);
    in_val = '0;
    chk("t4_pending", exp_q.size(), 0);
    // wrap-around from ptr 3
    do_reset();
    use_b = 1;
    out_rdy = 1;
    in_val = 4'b0100;
    expect_xfer(2);
    run(1);
    in_val = 4'b1001;
    expect_xfer(3);
    expect_xfer(0);
    run(2);
    in_val = '0;
    chk("t5_pending", exp_q.size(), 0);
    // reset while locked discards the lock
    do_reset();
    use_b = 0;
    in_val = 4'b0010;
    out_rdy = 0;
    @(negedge clk);
    chk("lock_val", 32'(val), 1);
    chk("lock_src", 32'(src), 1);
    @(posedge clk);
    #3;
    reset = 0;
    out_rdy = 1;
    #1;
    chk("mid_rst_val", 32'(val), 0);
    chk("mid_rst_rdy", 32'(rdy), 0);
    chk("mid_rst_src", 32'(src), 0);
    @(posedge clk);
    #1;
    in_val = 4'b0100;
    expect_xfer(2);
    reset = 1;
    run(1);
    in_val = '0;
    chk("t6_pending", exp_q.size(), 0);
    for (int i = 0; i < N; i++) chk("src_count", src_seq[i], exp_seq[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
